sd_fifo_share_arb: RTL and testbench
====================================

# sd_fifo_share_arb

Round-robin input arbiter that shares one downstream FIFO (e.g. a tail-write FIFO) among several srdy/drdy requesters. It enforces a per-requester occupancy quota so no source can fill the shared FIFO, tags each beat with its source ID, and tracks occupancy by observing pops on the FIFO read side. It sits directly in front of the shared FIFO's consumer port, with the FIFO's pop handshake fed back to it.

## Interface
- width, 8, data bits per beat
- inputs, 4, number of requesters (2..16)
- quota, 4, maximum entries per requester in flight (output register plus FIFO), at least 1
- idw, max(1,$clog2(inputs)), source ID width
- osz, $clog2(quota+1), occupancy counter width

Ports:
- clk  in  1  clock; all logic on rising edge
- reset_n  in  1  asynchronous active-low reset
- c_srdy  in  inputs  per-requester valid
- c_drdy  out  inputs  per-requester accept
- c_data  in  inputs*width  requester i occupies bits [i*width +: width]
- p_srdy  out  1  output beat valid (to FIFO c_srdy)
- p_drdy  in  1  FIFO ready (from FIFO c_drdy)
- p_data  out  width  output beat data
- p_id  out  idw  source index of output beat (stored alongside data in FIFO)
- r_vld  in  1  FIFO pop observed (FIFO p_srdy & p_drdy)
- r_id  in  idw  source ID of popped entry
- occ  out  inputs*osz  per-requester occupancy, requester i at [i*osz +: osz]
- err  out  1  sticky: pop observed for requester with zero occupancy, or r_id >= inputs

## Operation
- Eligibility: elig[i] = c_srdy[i] && occ[i] < quota.
- Output stage: one registered beat {p_data, p_id}; load_ok = !p_srdy || p_drdy.
- Arbitration: rr_ptr (idw bits) marks the highest-priority index. The winner is the first eligible i scanning rr_ptr, rr_ptr+1, … modulo inputs. Selection is combinational.
- c_drdy[i] = (i == winner) && elig[i] && load_ok. At most one c_drdy is high per cycle.
- Accept (c_srdy[w] && c_drdy[w]):
  - p_data <= c_data[w], p_id <= w, p_srdy <= 1
  - rr_ptr <= (w+1) mod inputs, with explicit wrap; inputs need not be a power of two
  - occ[w] increments
- p_drdy && p_srdy with no accept: p_srdy <= 0. p_data and p_id hold their values.
- Occupancy update:
  - Decrement occ[r_id] on r_vld.
  - Same-index increment and decrement in one cycle: no change.
  - Increment and decrement on different indices: both apply.
- Error handling:
  - r_vld with occ[r_id] == 0, or r_id >= inputs: no counter changes, err <= 1 until reset.
  - occ never exceeds quota; the eligibility gate guarantees this.
- No eligible requester: no c_drdy; rr_ptr holds.

## Timing
- Reset (async assert, sync-safe deassert via clk): p_srdy=0, p_data=0, p_id=0, rr_ptr=0, all occ=0, err=0. c_drdy is therefore 0 until a requester is eligible.
- Latency: a beat accepted in cycle N appears on p_srdy/p_data in cycle N+1.
- Throughput: one beat per cycle while p_drdy=1 and any requester is eligible.
- c_drdy depends combinationally on c_srdy, occ, rr_ptr, p_srdy and p_drdy. There is no dependency on r_vld; a pop frees quota for the next cycle, not the current one.
- Handshake: requesters hold c_data stable while c_srdy=1 && c_drdy=0. The output holds p_data/p_id stable while p_srdy=1 && p_drdy=0.
- Reset asserted mid-operation: the in-flight output beat is discarded. Occupancy of entries already in the FIFO is lost, so the FIFO must be reset together with this block.

## Test plan
- Reset, no traffic: p_srdy=0, c_drdy=0, occ all 0, err=0. Raise c_srdy[2] with data 0x5A: c_drdy[2]=1 that cycle. Next cycle p_srdy=1, p_data=0x5A, p_id=2, occ[2]=1.
- Fairness: all four c_srdy held high, p_drdy=1, r_vld pulsed every cycle for the previous winner. Grant order must be 0,1,2,3,0,1…, and occ stays at most 1 each.
- Quota: only c_srdy[1] high, p_drdy=1, no r_vld. Exactly 4 beats are accepted, then c_drdy[1]=0 with occ[1]=4. One r_vld with r_id=1 re-enables c_drdy[1] the next cycle.
- Backpressure: p_drdy=0 with p_srdy=1. All c_drdy=0, and p_data/p_id stay stable for 10 cycles. Releasing p_drdy moves one beat out, and a new beat is accepted in the same cycle.
- Simultaneous events: accept from requester 3 and r_vld with r_id=3 in the same cycle leaves occ[3] unchanged. A pop on requester 0 in the same cycle decrements occ[0] only.
- Error and wrap: inputs=3, grant goes 2→0. r_vld with r_id=1 while occ[1]=0 sets err=1, leaves counters unchanged, and err stays 1 until reset_n is low.

Source files
------------

// File: rtl/sd_fifo_share_arb.sv
// Round-robin arbiter sharing one downstream FIFO among requesters, with per-source quota and source-ID tagging.
// Latency: a beat accepted in cycle N is presented on p_srdy/p_data/p_id in cycle N+1.
// Backpressure: the output register holds while p_drdy=0; c_drdy stays low while the register is full or the winner is at quota.
module sd_fifo_share_arb #(
    parameter int width  = 8,
    parameter int inputs = 4,
    parameter int quota  = 4,
    parameter int idw    = (inputs > 1) ? $clog2(inputs) : 1,
    parameter int osz    = $clog2(quota + 1)
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic [inputs-1:0]       c_srdy,
    output logic [inputs-1:0]       c_drdy,
    input  logic [inputs*width-1:0] c_data,
    output logic                    p_srdy,
    input  logic                    p_drdy,
    output logic [width-1:0]        p_data,
    output logic [idw-1:0]          p_id,
    input  logic                    r_vld,
    input  logic [idw-1:0]          r_id,
    output logic [inputs*osz-1:0]   occ,
    output logic                    err
);

    // Per-requester count of beats in flight (output register plus FIFO).
    logic [osz-1:0]    occ_q [inputs];

    logic [idw-1:0]    rr_ptr;
    logic [inputs-1:0] elig;
    logic              load_ok;
    logic              win_vld;
    logic [idw-1:0]    win_idx;
    logic [idw:0]      cand;
    logic [width-1:0]  win_data;
    logic              accept;
    logic [idw-1:0]    rr_next;
    logic [inputs-1:0] inc_vec;
    logic [inputs-1:0] dec_vec;
    logic              pop_ok;
    logic              pop_bad;

    // A requester may compete only while it is below its quota.
    always_comb begin
        elig = '0;
        for (int i = 0; i < inputs; i++) begin
            elig[i] = c_srdy[i] && (occ_q[i] < osz'(quota));
        end
    end

    // The output register can take a new beat when empty or being drained this cycle.
    assign load_ok = !p_srdy || p_drdy;

    // Scan from rr_ptr upward with explicit wrap; first eligible index wins.
    always_comb begin
        win_vld = 1'b0;
        win_idx = '0;
        cand    = '0;
        for (int k = 0; k < inputs; k++) begin
            cand = {1'b0, rr_ptr} + (idw+1)'(k);
            if (cand >= (idw+1)'(inputs)) begin
                cand = cand - (idw+1)'(inputs);
            end
            if (!win_vld && elig[cand[idw-1:0]]) begin
                win_vld = 1'b1;
                win_idx = cand[idw-1:0];
            end
        end
    end

    // Grant only the winner, and only when the output register can load.
    always_comb begin
        c_drdy = '0;
        for (int i = 0; i < inputs; i++) begin
            c_drdy[i] = win_vld && load_ok && (win_idx == idw'(i));
        end
    end

    // Steer the winner's data lane toward the output register.
    always_comb begin
        win_data = '0;
        for (int i = 0; i < inputs; i++) begin
            if (win_idx == idw'(i)) begin
                win_data = c_data[i*width +: width];
            end
        end
    end

    // A grant implies the winner is eligible, hence c_srdy is high.
    assign accept  = win_vld && load_ok;
    assign rr_next = (win_idx == idw'(inputs - 1)) ? '0 : win_idx + idw'(1);

    // Per-index increment (accept) and decrement (legal pop) requests.
    always_comb begin
        inc_vec = '0;
        dec_vec = '0;
        pop_ok  = 1'b0;
        for (int i = 0; i < inputs; i++) begin
            inc_vec[i] = accept && (win_idx == idw'(i));
            if (r_vld && (r_id == idw'(i)) && (occ_q[i] != '0)) begin
                dec_vec[i] = 1'b1;
                pop_ok     = 1'b1;
            end
        end
    end

    // A pop is bad if its ID is out of range or that requester has nothing in flight.
    assign pop_bad = r_vld && !pop_ok;

    // Output register and round-robin pointer.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            p_srdy <= 1'b0;
            p_data <= '0;
            p_id   <= '0;
            rr_ptr <= '0;
        end else if (accept) begin
            p_srdy <= 1'b1;
            p_data <= win_data;
            p_id   <= win_idx;
            rr_ptr <= rr_next;
        end else if (p_drdy) begin
            p_srdy <= 1'b0;
        end
    end

    // Occupancy counters; coincident inc and dec on one index cancel.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < inputs; i++) begin
                occ_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < inputs; i++) begin
                case ({inc_vec[i], dec_vec[i]})
                    2'b10:   occ_q[i] <= occ_q[i] + osz'(1);
                    2'b01:   occ_q[i] <= occ_q[i] - osz'(1);
                    default: occ_q[i] <= occ_q[i];
                endcase
            end
        end
    end

    // Sticky error flag, cleared only by reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            err <= 1'b0;
        end else if (pop_bad) begin
            err <= 1'b1;
        end
    end

    // Flatten the counters onto the occupancy port.
    always_comb begin
        occ = '0;
        for (int i = 0; i < inputs; i++) begin
            occ[i*osz +: osz] = occ_q[i];
        end
    end

    a_drdy_onehot: assert property (@(posedge clk) disable iff (!reset_n) $onehot0(c_drdy));

    a_out_stable: assert property (@(posedge clk) disable iff (!reset_n)
        (p_srdy && !p_drdy) |=> (p_srdy && $stable(p_data) && $stable(p_id)));

endmodule

// File: tb/tb_sd_fifo_share_arb.sv
// Directed bench for sd_fifo_share_arb: vector table on a 4-input instance, hand sequences for reset and a 3-input instance.
// Vectors are driven on the falling edge; c_drdy is sampled before the rising edge, registers 1 time unit after it.
// Backpressure is exercised by stalling p_drdy for ten cycles in the table.
module tb_sd_fifo_share_arb;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [3:0]  c_srdy;
    logic [3:0]  c_drdy;
    logic [31:0] c_data;
    logic        p_srdy;
    logic        p_drdy;
    logic [7:0]  p_data;
    logic [1:0]  p_id;
    logic        r_vld;
    logic [1:0]  r_id;
    logic [11:0] occ;
    logic        err;

    logic        rst3_n;
    logic [2:0]  c3_srdy;
    logic [2:0]  c3_drdy;
    logic [23:0] c3_data;
    logic        p3_srdy;
    logic        p3_drdy;
    logic [7:0]  p3_data;
    logic [1:0]  p3_id;
    logic        r3_vld;
    logic [1:0]  r3_id;
    logic [8:0]  occ3;
    logic        err3;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    sd_fifo_share_arb #(.width(8), .inputs(4), .quota(4)) u_dut (
        .clk(clk), .reset_n(reset_n),
        .c_srdy(c_srdy), .c_drdy(c_drdy), .c_data(c_data),
        .p_srdy(p_srdy), .p_drdy(p_drdy), .p_data(p_data), .p_id(p_id),
        .r_vld(r_vld), .r_id(r_id), .occ(occ), .err(err)
    );

    sd_fifo_share_arb #(.width(8), .inputs(3), .quota(4)) u_dut3 (
        .clk(clk), .reset_n(rst3_n),
        .c_srdy(c3_srdy), .c_drdy(c3_drdy), .c_data(c3_data),
        .p_srdy(p3_srdy), .p_drdy(p3_drdy), .p_data(p3_data), .p_id(p3_id),
        .r_vld(r3_vld), .r_id(r3_id), .occ(occ3), .err(err3)
    );

    typedef struct {
        logic [3:0]  srdy;
        logic [31:0] data;
        logic        pdrdy;
        logic        rvld;
        logic [1:0]  rid;
        logic [3:0]  e_drdy;
        logic        e_psrdy;
        logic [7:0]  e_pdata;
        logic [1:0]  e_pid;
        logic [11:0] e_occ;
        logic        e_err;
    } vec_t;

    vec_t tbl [$];

    function automatic logic [11:0] occv(input int o0, input int o1, input int o2, input int o3);
        return {3'(o3), 3'(o2), 3'(o1), 3'(o0)};
    endfunction

    function automatic logic [8:0] occ3v(input int o0, input int o1, input int o2);
        return {3'(o2), 3'(o1), 3'(o0)};
    endfunction

    function automatic vec_t mk(input logic [3:0] s, input logic [31:0] d, input logic pd,
                                input logic rv, input logic [1:0] ri, input logic [3:0] ed,
                                input logic eps, input logic [7:0] epd, input logic [1:0] epi,
                                input logic [11:0] eo, input logic ee);
        vec_t v;
        v.srdy = s; v.data = d; v.pdrdy = pd; v.rvld = rv; v.rid = ri;
        v.e_drdy = ed; v.e_psrdy = eps; v.e_pdata = epd; v.e_pid = epi; v.e_occ = eo; v.e_err = ee;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic apply(input vec_t v, input int n);
        @(negedge clk);
        c_srdy = v.srdy; c_data = v.data; p_drdy = v.pdrdy; r_vld = v.rvld; r_id = v.rid;
        #1;
        chk($sformatf("v%0d c_drdy", n), 32'(c_drdy), 32'(v.e_drdy));
        @(posedge clk);
        #1;
        chk($sformatf("v%0d p_srdy", n), 32'(p_srdy), 32'(v.e_psrdy));
        chk($sformatf("v%0d p_data", n), 32'(p_data), 32'(v.e_pdata));
        chk($sformatf("v%0d p_id",   n), 32'(p_id),   32'(v.e_pid));
        chk($sformatf("v%0d occ",    n), 32'(occ),    32'(v.e_occ));
        chk($sformatf("v%0d err",    n), 32'(err),    32'(v.e_err));
    endtask

    localparam logic [31:0] D = 32'h44332211;

    initial begin
        // Row numbers in comments track the hand-computed round-robin pointer (rr).
        tbl.push_back(mk(4'b0100, 32'h445A2211, 1'b1, 1'b0, 2'd0, 4'b0100, 1'b1, 8'h5A, 2'd2, occv(0,0,1,0), 1'b0)); // rr->3
        tbl.push_back(mk(4'b0000, D,            1'b1, 1'b1, 2'd2, 4'b0000, 1'b0, 8'h5A, 2'd2, occv(0,0,0,0), 1'b0));
        tbl.push_back(mk(4'b1111, D,            1'b1, 1'b0, 2'd0, 4'b1000, 1'b1, 8'h44, 2'd3, occv(0,0,0,1), 1'b0)); // rr->0
        tbl.push_back(mk(4'b1111, D,            1'b1, 1'b1, 2'd3, 4'b0001, 1'b1, 8'h11, 2'd0, occv(1,0,0,0), 1'b0));
        tbl.push_back(mk(4'b1111, D,            1'b1, 1'b1, 2'd0, 4'b0010, 1'b1, 8'h22, 2'd1, occv(0,1,0,0), 1'b0));
        tbl.push_back(mk(4'b1111, D,            1'b1, 1'b1, 2'd1, 4'b0100, 1'b1, 8'h33, 2'd2, occv(0,0,1,0), 1'b0));
        tbl.push_back(mk(4'b1111, D,            1'b1, 1'b1, 2'd2, 4'b1000, 1'b1, 8'h44, 2'd3, occv(0,0,0,1), 1'b0));
        tbl.push_back(mk(4'b1111, D,            1'b1, 1'b1, 2'd3, 4'b0001, 1'b1, 8'h11, 2'd0, occv(1,0,0,0), 1'b0)); // rr->1
        tbl.push_back(mk(4'b0000, D,            1'b1, 1'b1, 2'd0, 4'b0000, 1'b0, 8'h11, 2'd0, occv(0,0,0,0), 1'b0));
        // Quota: requester 1 alone fills to 4, then stalls until a pop frees an entry.
        tbl.push_back(mk(4'b0010, 32'h4433A111, 1'b1, 1'b0, 2'd0, 4'b0010, 1'b1, 8'hA1, 2'd1, occv(0,1,0,0), 1'b0));
        tbl.push_back(mk(4'b0010, 32'h4433A211, 1'b1, 1'b0, 2'd0, 4'b0010, 1'b1, 8'hA2, 2'd1, occv(0,2,0,0), 1'b0));
        tbl.push_back(mk(4'b0010, 32'h4433A311, 1'b1, 1'b0, 2'd0, 4'b0010, 1'b1, 8'hA3, 2'd1, occv(0,3,0,0), 1'b0));
        tbl.push_back(mk(4'b0010, 32'h4433A411, 1'b1, 1'b0, 2'd0, 4'b0010, 1'b1, 8'hA4, 2'd1, occv(0,4,0,0), 1'b0));
        tbl.push_back(mk(4'b0010, 32'h4433A511, 1'b1, 1'b0, 2'd0, 4'b0000, 1'b0, 8'hA4, 2'd1, occv(0,4,0,0), 1'b0));
        tbl.push_back(mk(4'b0010, 32'h4433A511, 1'b1, 1'b1, 2'd1, 4'b0000, 1'b0, 8'hA4, 2'd1, occv(0,3,0,0), 1'b0));
        tbl.push_back(mk(4'b0010, 32'h4433A511, 1'b1, 1'b0, 2'd0, 4'b0010, 1'b1, 8'hA5, 2'd1, occv(0,4,0,0), 1'b0)); // rr->2
        // Backpressure: ten stalled cycles, the first one also pops requester 1.
        tbl.push_back(mk(4'b0101, D,            1'b0, 1'b1, 2'd1, 4'b0000, 1'b1, 8'hA5, 2'd1, occv(0,3,0,0), 1'b0));
        for (int k = 0; k < 9; k++) begin
            tbl.push_back(mk(4'b0101, D,        1'b0, 1'b0, 2'd0, 4'b0000, 1'b1, 8'hA5, 2'd1, occv(0,3,0,0), 1'b0));
        end
        tbl.push_back(mk(4'b0101, D,            1'b1, 1'b0, 2'd0, 4'b0100, 1'b1, 8'h33, 2'd2, occv(0,3,1,0), 1'b0)); // rr->3
        // Simultaneous accept and pop.
        tbl.push_back(mk(4'b1000, D,            1'b1, 1'b0, 2'd0, 4'b1000, 1'b1, 8'h44, 2'd3, occv(0,3,1,1), 1'b0)); // rr->0
        tbl.push_back(mk(4'b1000, 32'h4B332211, 1'b1, 1'b1, 2'd3, 4'b1000, 1'b1, 8'h4B, 2'd3, occv(0,3,1,1), 1'b0));
        tbl.push_back(mk(4'b0001, 32'h44332210, 1'b1, 1'b0, 2'd0, 4'b0001, 1'b1, 8'h10, 2'd0, occv(1,3,1,1), 1'b0)); // rr->1
        tbl.push_back(mk(4'b1000, 32'h4C332211, 1'b1, 1'b1, 2'd0, 4'b1000, 1'b1, 8'h4C, 2'd3, occv(0,3,1,2), 1'b0)); // rr->0
        // Pop of an empty requester sets err; a later legal pop still applies.
        tbl.push_back(mk(4'b0000, D,            1'b1, 1'b1, 2'd0, 4'b0000, 1'b0, 8'h4C, 2'd3, occv(0,3,1,2), 1'b1));
        tbl.push_back(mk(4'b0000, D,            1'b1, 1'b1, 2'd2, 4'b0000, 1'b0, 8'h4C, 2'd3, occv(0,3,0,2), 1'b1));

        reset_n = 1'b0; rst3_n = 1'b0;
        c_srdy = '0; c_data = '0; p_drdy = 1'b0; r_vld = 1'b0; r_id = '0;
        c3_srdy = '0; c3_data = '0; p3_drdy = 1'b0; r3_vld = 1'b0; r3_id = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1; rst3_n = 1'b1;
        #1;
        chk("reset p_srdy", 32'(p_srdy), 32'd0);
        chk("reset c_drdy", 32'(c_drdy), 32'd0);
        chk("reset p_data", 32'(p_data), 32'd0);
        chk("reset p_id",   32'(p_id),   32'd0);
        chk("reset occ",    32'(occ),    32'd0);
        chk("reset err",    32'(err),    32'd0);

        for (int n = 0; n < tbl.size(); n++) begin
            apply(tbl[n], n);
        end

        // Reset mid-operation discards the in-flight beat and clears rr_ptr, occ and err.
        @(negedge clk);
        c_srdy = 4'b1111; c_data = D; p_drdy = 1'b0; r_vld = 1'b0;
        @(posedge clk);
        #1;
        chk("midrst beat p_srdy", 32'(p_srdy), 32'd1);
        chk("midrst beat p_id",   32'(p_id),   32'd0);
        #2;
        reset_n = 1'b0;
        c_srdy  = 4'b0000;
        #1;
        chk("midrst p_srdy", 32'(p_srdy), 32'd0);
        chk("midrst p_data", 32'(p_data), 32'd0);
        chk("midrst p_id",   32'(p_id),   32'd0);
        chk("midrst occ",    32'(occ),    32'd0);
        chk("midrst err",    32'(err),    32'd0);
        chk("midrst c_drdy", 32'(c_drdy), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        c_srdy = 4'b1001; p_drdy = 1'b1;
        #1;
        chk("postrst rr_ptr c_drdy", 32'(c_drdy), 32'b0001);
        @(negedge clk);
        c_srdy = 4'b0000;

        // Three-input instance: pointer wraps 2 -> 0, error flag is sticky.
        @(negedge clk);
        c3_srdy = 3'b100; c3_data = 24'hC2C1C0; p3_drdy = 1'b1;
        #1;
        chk("in3 grant 2", 32'(c3_drdy), 32'b100);
        @(posedge clk);
        #1;
        chk("in3 p_srdy", 32'(p3_srdy), 32'd1);
        chk("in3 p_id 2", 32'(p3_id),   32'd2);
        chk("in3 p_data", 32'(p3_data), 32'hC2);
        chk("in3 occ a",  32'(occ3),    32'(occ3v(0,0,1)));
        @(negedge clk);
        c3_srdy = 3'b111;
        #1;
        chk("in3 wrap grant 0", 32'(c3_drdy), 32'b001);
        @(posedge clk);
        #1;
        chk("in3 p_id 0", 32'(p3_id),   32'd0);
        chk("in3 p_data0", 32'(p3_data), 32'hC0);
        chk("in3 occ b",  32'(occ3),    32'(occ3v(1,0,1)));
        @(negedge clk);
        c3_srdy = 3'b000; r3_vld = 1'b1; r3_id = 2'd1;
        @(posedge clk);
        #1;
        chk("in3 err empty pop", 32'(err3), 32'd1);
        chk("in3 occ unchanged", 32'(occ3), 32'(occ3v(1,0,1)));
        @(negedge clk);
        r3_vld = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            #1;
            chk($sformatf("in3 err sticky %0d", k), 32'(err3), 32'd1);
        end
        @(negedge clk);
        rst3_n = 1'b0;
        #1;
        chk("in3 err cleared", 32'(err3), 32'd0);
        chk("in3 occ cleared", 32'(occ3), 32'd0);
        @(negedge clk);
        rst3_n = 1'b1;
        r3_vld = 1'b1; r3_id = 2'd3;
        @(posedge clk);
        #1;
        chk("in3 err bad id",     32'(err3), 32'd1);
        chk("in3 occ after bad",  32'(occ3), 32'd0);
        @(negedge clk);
        r3_vld = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
